// File: rtl/w_order_scheduler.sv
// Per-destination W write-order scheduler: records AW grant order per destination and passes
// only the head source's W beats until its WLAST. Optional same-cycle bypass: W_ORDER_BYPASS_EN.
module w_order_fifo #(
  parameter int DEPTH = 4,
  parameter int LOG_M = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [LOG_M-1:0] pushSrc,
  input  logic             pop,
  output logic             headVld,
  output logic [LOG_M-1:0] head,
  output logic             full,
  output logic             ovf
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][LOG_M-1:0] mem;
  logic [PW-1:0]               wptr, rptr;
  logic [CW-1:0]               count;
  logic                        pushOk, popOk, empty;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign pushOk = push & ~full;
  assign ovf    = push & full;

`ifdef W_ORDER_BYPASS_EN
  // An empty FIFO presents the incoming grant as head in the same cycle.
  assign headVld = ~empty | push;
  assign head    = empty ? pushSrc : mem[rptr];
`else
  assign headVld = ~empty;
  assign head    = mem[rptr];
`endif

  assign popOk = pop & headVld;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (pushOk) begin
        mem[wptr] <= pushSrc;
        wptr      <= wptr + PW'(1);
      end
      if (popOk) rptr <= rptr + PW'(1);
      count <= count + CW'(pushOk) - CW'(popOk);
    end
  end
endmodule

module w_order_scheduler #(
  parameter int M     = 2,
  parameter int N     = 2,
  parameter int DEPTH = 4,
  parameter int LOG_M = (M > 1) ? $clog2(M) : 1,
  parameter int LOG_N = (N > 1) ? $clog2(N) : 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [N-1:0]              awPush_i,
  input  logic [N-1:0][LOG_M-1:0]   awSrc_i,
  output logic [N-1:0]              awStall_o,
  input  logic [M-1:0]              srcWVld_i,
  input  logic [M-1:0][LOG_N-1:0]   srcWTarget_i,
  input  logic [M-1:0]              srcWLast_i,
  output logic [M-1:0]              srcWRdy_o,
  input  logic [N-1:0]              dstWRdy_i,
  output logic [N-1:0]              dstWVld_o,
  output logic [N-1:0][LOG_M-1:0]   dstWSel_o,
  output logic                      errOvf_o
);
  logic [N-1:0]            hv, pop, ovf;
  logic [N-1:0][LOG_M-1:0] head;

  for (genvar d = 0; d < N; d++) begin : gDst
    w_order_fifo #(.DEPTH(DEPTH), .LOG_M(LOG_M)) uFifo (
      .clk     (clk),
      .rstn    (rstn),
      .push    (awPush_i[d]),
      .pushSrc (awSrc_i[d]),
      .pop     (pop[d]),
      .headVld (hv[d]),
      .head    (head[d]),
      .full    (awStall_o[d]),
      .ovf     (ovf[d])
    );
    assign dstWSel_o[d] = hv[d] ? head[d] : '0;
  end

  // Only the head source of a destination can match it, so each d has at most one driver.
  always_comb begin
    dstWVld_o = '0;
    srcWRdy_o = '0;
    pop       = '0;
    for (int s = 0; s < M; s++) begin
      for (int d = 0; d < N; d++) begin
        if (srcWVld_i[s] && srcWTarget_i[s] == LOG_N'(d) && hv[d] && head[d] == LOG_M'(s)) begin
          dstWVld_o[d] = 1'b1;
          if (dstWRdy_i[d]) begin
            srcWRdy_o[s] = 1'b1;
            if (srcWLast_i[s]) pop[d] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) errOvf_o <= 1'b0;
    else       errOvf_o <= errOvf_o | (|ovf);
  end
endmodule

// File: tb/tb_w_order_scheduler.sv
// Bench for w_order_scheduler: directed vector table, hand sequences, and random traffic
// checked against a queue-based order model.
module tb_w_order_scheduler;
  localparam int M = 2, N = 2, DEPTH = 4, LOG_M = 1, LOG_N = 1;

  logic                    clk = 1'b0, rstn = 1'b0;
  logic [N-1:0]            awPush = '0;
  logic [N-1:0][LOG_M-1:0] awSrc = '0;
  logic [N-1:0]            awStall;
  logic [M-1:0]            wVld = '0, wLast = '0, wRdy;
  logic [M-1:0][LOG_N-1:0] wTgt = '0;
  logic [N-1:0]            dRdy = '0, dVld;
  logic [N-1:0][LOG_M-1:0] dSel;
  logic                    errOvf;

  int nChecks = 0, nErrors = 0;

  w_order_scheduler #(.M(M), .N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .awPush_i(awPush), .awSrc_i(awSrc), .awStall_o(awStall),
    .srcWVld_i(wVld), .srcWTarget_i(wTgt), .srcWLast_i(wLast), .srcWRdy_o(wRdy),
    .dstWRdy_i(dRdy), .dstWVld_o(dVld), .dstWSel_o(dSel), .errOvf_o(errOvf));

  always #5 clk = ~clk;

  // Reference: one queue of granted source ids per destination.
  int q [N][$];
  bit mOvf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_out(output logic [N-1:0] eVld, output logic [N-1:0][LOG_M-1:0] eSel,
                           output logic [M-1:0] eRdy, output logic [N-1:0] eStall);
    bit hv [N];
    int h  [N];
    eVld = '0; eSel = '0; eRdy = '0; eStall = '0;
    if (!rstn) return;
    for (int d = 0; d < N; d++) begin
      hv[d] = q[d].size() > 0;
      h[d]  = hv[d] ? q[d][0] : 0;
`ifdef W_ORDER_BYPASS_EN
      if (!hv[d] && awPush[d]) begin hv[d] = 1'b1; h[d] = int'(awSrc[d]); end
`endif
      if (hv[d]) eSel[d] = LOG_M'(h[d]);
      eStall[d] = q[d].size() == DEPTH;
    end
    for (int s = 0; s < M; s++) begin
      int t = int'(wTgt[s]);
      if (wVld[s] && t < N && hv[t] && h[t] == s) begin
        eVld[t] = 1'b1;
        eRdy[s] = dRdy[t];
      end
    end
  endtask

  task automatic check_model();
    logic [N-1:0] eVld, eStall;
    logic [N-1:0][LOG_M-1:0] eSel;
    logic [M-1:0] eRdy;
    model_out(eVld, eSel, eRdy, eStall);
    chk("m_dstWVld", 32'(dVld), 32'(eVld));
    chk("m_dstWSel", 32'(dSel), 32'(eSel));
    chk("m_srcWRdy", 32'(wRdy), 32'(eRdy));
    chk("m_awStall", 32'(awStall), 32'(eStall));
    chk("m_errOvf", 32'(errOvf), 32'(rstn ? mOvf : 1'b0));
  endtask

  task automatic update_model();
    logic [N-1:0] eVld, eStall;
    logic [N-1:0][LOG_M-1:0] eSel;
    logic [M-1:0] eRdy;
    if (!rstn) begin
      for (int d = 0; d < N; d++) q[d].delete();
      mOvf = 1'b0;
      return;
    end
    model_out(eVld, eSel, eRdy, eStall);
    for (int d = 0; d < N; d++) begin
      bit wasFull = q[d].size() == DEPTH;
      bit popD = 1'b0;
      for (int s = 0; s < M; s++)
        if (eRdy[s] && wLast[s] && int'(wTgt[s]) == d) popD = 1'b1;
      if (awPush[d]) begin
        if (wasFull) mOvf = 1'b1;
        else q[d].push_back(int'(awSrc[d]));
      end
      if (popD) void'(q[d].pop_front());
    end
  endtask

  task automatic half();
    @(negedge clk);
    check_model();
  endtask

  task automatic edge_();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic drive(input logic [1:0] ap, as, wv, wt, wl, dr);
    awPush = ap; awSrc = as; wVld = wv; wTgt = wt; wLast = wl; dRdy = dr;
  endtask

  task automatic do_reset();
    drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11);
    rstn = 1'b0;
    edge_();
    edge_();
    rstn = 1'b1;
  endtask

  typedef struct {
    logic [1:0] ap, as, wv, wt, wl, dr;
    logic [1:0] eRdy, eVld, eSel, eStall;
    logic       eOvf;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic [1:0] ap, as, wv, wt, wl, dr, eRdy, eVld, eSel, eStall,
                              logic eOvf);
    vec_t v;
    v.ap = ap; v.as = as; v.wv = wv; v.wt = wt; v.wl = wl; v.dr = dr;
    v.eRdy = eRdy; v.eVld = eVld; v.eSel = eSel; v.eStall = eStall; v.eOvf = eOvf;
    return v;
  endfunction

  initial begin
    // Fields: awPush awSrc wVld wTgt wLast dRdy | rdy dVld sel stall ovf
    // 3-beat burst src1->d0, first beat visible one cycle after the grant
    tbl.push_back(mk(2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b11, 2'b10, 2'b01, 2'b01, 2'b00, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b11, 2'b10, 2'b01, 2'b01, 2'b00, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b11, 2'b10, 2'b01, 2'b01, 2'b00, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    // src0 then src1 granted at d0; src1 waits for src0's WLAST
    tbl.push_back(mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    tbl.push_back(mk(2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b11, 2'b00, 2'b01, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b10, 2'b01, 2'b01, 2'b00, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b11, 2'b10, 2'b01, 2'b01, 2'b00, 0));
    // independent destinations, with one cycle of d1 backpressure
    tbl.push_back(mk(2'b11, 2'b10, 2'b11, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b00, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    // fill d0, overflow push, then one pop frees a slot
    tbl.push_back(mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    tbl.push_back(mk(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    tbl.push_back(mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    tbl.push_back(mk(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    tbl.push_back(mk(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 1));
    tbl.push_back(mk(2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 1));
    tbl.push_back(mk(2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 1));

    // Reset state
    rstn = 1'b0;
    #1;
    chk("rst_dstWVld", 32'(dVld), 0);
    chk("rst_dstWSel", 32'(dSel), 0);
    chk("rst_srcWRdy", 32'(wRdy), 0);
    chk("rst_awStall", 32'(awStall), 0);
    chk("rst_errOvf", 32'(errOvf), 0);
    do_reset();

`ifndef W_ORDER_BYPASS_EN
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ap, tbl[i].as, tbl[i].wv, tbl[i].wt, tbl[i].wl, tbl[i].dr);
      half();
      chk($sformatf("v%0d_srcWRdy", i), 32'(wRdy), 32'(tbl[i].eRdy));
      chk($sformatf("v%0d_dstWVld", i), 32'(dVld), 32'(tbl[i].eVld));
      chk($sformatf("v%0d_dstWSel", i), 32'(dSel), 32'(tbl[i].eSel));
      chk($sformatf("v%0d_awStall", i), 32'(awStall), 32'(tbl[i].eStall));
      chk($sformatf("v%0d_errOvf", i), 32'(errOvf), 32'(tbl[i].eOvf));
      edge_();
    end
`else
    // Same-cycle grant and single-beat WLAST on d1
    drive(2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10);
    half();
    chk("byp_srcWRdy", 32'(wRdy), 32'h2);
    chk("byp_dstWVld", 32'(dVld), 32'h2);
    chk("byp_dstWSel", 32'(dSel), 32'h2);
    edge_();
    drive(2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10);
    half();
    chk("byp_empty_rdy", 32'(wRdy), 0);
    chk("byp_empty_sel", 32'(dSel), 0);
    edge_();
`endif

    // Full FIFO with simultaneous pop and push: push dropped, count drops to 3
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11);
      half();
      edge_();
    end
    drive(2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01);
    half();
    chk("fpp_stall", 32'(awStall), 32'h1);
    chk("fpp_rdy", 32'(wRdy), 32'h1);
    edge_();
    drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11);
    half();
    chk("fpp_ovf", 32'(errOvf), 32'h1);
    chk("fpp_stall_after", 32'(awStall), 0);
    edge_();
    drive(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11);
    half();
    edge_();
    drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11);
    half();
    chk("fpp_count3_refill", 32'(awStall), 32'h1);
    edge_();

    // Reset in the middle of a burst
    do_reset();
    drive(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11);
    half();
    edge_();
    drive(2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b11);
    half();
    chk("mid_beat", 32'(wRdy), 32'h2);
    rstn = 1'b0;
    #1;
    chk("mid_rst_rdy", 32'(wRdy), 0);
    chk("mid_rst_vld", 32'(dVld), 0);
    chk("mid_rst_sel", 32'(dSel), 0);
    edge_();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      half();
      chk("post_rst_blocked", 32'(wRdy), 0);
      edge_();
    end

    // Random traffic against the order model, with occasional resets
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < N; d++) begin
        awPush[d] = ($urandom_range(0, 3) == 0);
        awSrc[d]  = LOG_M'($urandom_range(0, M - 1));
        dRdy[d]   = ($urandom_range(0, 3) != 0);
      end
      for (int s = 0; s < M; s++) begin
        wVld[s]  = ($urandom_range(0, 3) != 0);
        wTgt[s]  = LOG_N'($urandom_range(0, N - 1));
        wLast[s] = ($urandom_range(0, 2) == 0);
      end
      rstn = ($urandom_range(0, 499) != 0);
      half();
      edge_();
    end

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end
endmodule
